alu_pool_pipelined: RTL and testbench

- Next-generation ALU resource pool: NUM_PORTS requesters share NUM_UNITS multi-cycle ALU units of parametrised width.
- Allocation is age-ordered: the smallest issue_id wins, so the oldest instruction is served first.
- Each unit stays locked to its owner from grant until release. Results are held in the unit until the owner releases it.
- Sits between the SIC array and execution; adds configurable latency, abort-on-release and result-valid handshake.

---
 rtl/alu_pool_pipelined.sv | 217 +++++++++++++++++++++
 tb/tb_alu_pool_pipelined.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pool_pipelined.sv
// Shared pool of multi-cycle ALU units. Requesters are served oldest issue_id first
// and each unit stays locked to its owner port until that port releases it.
module alu_pool_pipelined #(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 16,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int LAT       = 2,
  localparam int UIDX_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  issue_id     [NUM_PORTS],
  input  logic [DATA_W-1:0]    op_a         [NUM_PORTS],
  input  logic [DATA_W-1:0]    op_b         [NUM_PORTS],
  input  logic [OP_W-1:0]      op_code      [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] release_lock,
  output logic [NUM_PORTS-1:0] grant,
  output logic [UIDX_W-1:0]    alloc_id     [NUM_PORTS],
  output logic [NUM_PORTS-1:0] owns,
  output logic [NUM_PORTS-1:0] res_valid,
  output logic [DATA_W-1:0]    res          [NUM_PORTS],
  output logic [NUM_PORTS-1:0] zero,
  output logic [NUM_PORTS-1:0] over,
  output logic                 pool_full
);

  localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SH_W   = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(7);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} unit_state_e;

  unit_state_e             state      [NUM_UNITS];
  unit_state_e             state_nx   [NUM_UNITS];
  logic [CNT_W-1:0]        cnt        [NUM_UNITS];
  logic [CNT_W-1:0]        cnt_nx     [NUM_UNITS];
  logic [PIDX_W-1:0]       owner      [NUM_UNITS];
  logic [PIDX_W-1:0]       owner_nx   [NUM_UNITS];
  logic [PIDX_W-1:0]       unit_port  [NUM_UNITS];
  logic [OP_W-1:0]         op_p0      [NUM_UNITS];
  logic signed [DATA_W-1:0] a_p0      [NUM_UNITS];
  logic signed [DATA_W-1:0] b_p0      [NUM_UNITS];
  logic [DATA_W:0]         alu_p0     [NUM_UNITS];
  logic [NUM_UNITS-1:0]    idle;
  logic [NUM_UNITS-1:0]    unit_grant;
  logic [NUM_UNITS-1:0]    unit_rel;
  logic [NUM_UNITS-1:0]    vld_p0;
  logic [NUM_PORTS-1:0]    elig;
  logic [UIDX_W-1:0]       grant_unit [NUM_PORTS];
  logic [UIDX_W-1:0]       own_unit   [NUM_PORTS];
  int unsigned             free_rank  [NUM_UNITS];
  int unsigned             port_rank  [NUM_PORTS];
  int unsigned             nfree;

  // Returns {signed_overflow, result}.
  function automatic logic [DATA_W:0] alu_f(input logic [OP_W-1:0] op,
                                            input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    logic                     ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        r  = a + b;
        ov = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        r  = a - b;
        ov = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (a < b) ? DATA_W'(1) : '0;
      OP_SLL:  r = a << b[SH_W-1:0];
      OP_SRL:  r = a >> b[SH_W-1:0];
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      idle[u]     = (state[u] == IDLE);
      unit_rel[u] = (state[u] != IDLE) && release_lock[owner[u]];
      vld_p0[u]   = (state[u] == DONE) || ((state[u] == EXEC) && (cnt[u] == '0));
      alu_p0[u]   = alu_f(op_p0[u], a_p0[u], b_p0[u]);
    end
  end

  assign pool_full = ~|idle;

  // Port view of ownership, derived purely from registered unit state.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      owns[p]      = 1'b0;
      res_valid[p] = 1'b0;
      res[p]       = '0;
      zero[p]      = 1'b0;
      over[p]      = 1'b0;
      own_unit[p]  = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (!idle[u] && (owner[u] == PIDX_W'(p))) begin
          owns[p]     = 1'b1;
          own_unit[p] = UIDX_W'(u);
          if (vld_p0[u]) begin
            res_valid[p] = 1'b1;
            res[p]       = alu_p0[u][DATA_W-1:0];
            over[p]      = alu_p0[u][DATA_W];
            zero[p]      = (alu_p0[u][DATA_W-1:0] == '0);
          end
        end
      end
    end
  end

  assign elig = req & ~owns;

  // Age-ordered allocation: k-th oldest eligible port takes the k-th lowest free unit.
  always_comb begin
    nfree = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      free_rank[u] = nfree;
      if (idle[u]) nfree = nfree + 1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_rank[p] = 0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (elig[q] && ((issue_id[q] < issue_id[p]) ||
                        ((issue_id[q] == issue_id[p]) && (q < p))))
          port_rank[p] = port_rank[p] + 1;
      end
    end
    grant      = '0;
    unit_grant = '0;
    for (int p = 0; p < NUM_PORTS; p++) grant_unit[p] = '0;
    for (int u = 0; u < NUM_UNITS; u++) unit_port[u] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (elig[p] && idle[u] && (free_rank[u] == port_rank[p])) begin
          grant[p]      = 1'b1;
          grant_unit[p] = UIDX_W'(u);
          unit_grant[u] = 1'b1;
          unit_port[u]  = PIDX_W'(p);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      alloc_id[p] = grant[p] ? grant_unit[p] : own_unit[p];
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      state_nx[u] = state[u];
      cnt_nx[u]   = cnt[u];
      owner_nx[u] = owner[u];
      case (state[u])
        IDLE: if (unit_grant[u]) begin
          state_nx[u] = EXEC;
          cnt_nx[u]   = CNT_W'(LAT - 1);
          owner_nx[u] = unit_port[u];
        end
        EXEC: begin
          if (unit_rel[u])          state_nx[u] = IDLE;
          else if (cnt[u] == '0)    state_nx[u] = DONE;
          else                      cnt_nx[u]   = cnt[u] - CNT_W'(1);
        end
        DONE:    if (unit_rel[u]) state_nx[u] = IDLE;
        default: state_nx[u] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state[u] <= IDLE;
        cnt[u]   <= '0;
        owner[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state[u] <= state_nx[u];
        cnt[u]   <= cnt_nx[u];
        owner[u] <= owner_nx[u];
      end
    end
  end

  // Stage p0: operands captured in the grant cycle and held until release.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_grant[u]) begin
        op_p0[u] <= op_code[unit_port[u]];
        a_p0[u]  <= $signed(op_a[unit_port[u]]);
        b_p0[u]  <= $signed(op_b[unit_port[u]]);
      end
    end
  end

endmodule

// File: tb/tb_alu_pool_pipelined.sv
// Bench for alu_pool_pipelined: op table through a scoreboard, then arbitration,
// tie-break, abort and mid-operation reset sequences.
module tb_alu_pool_pipelined;
  localparam int NP  = 5;
  localparam int NU  = 4;
  localparam int IW  = 16;
  localparam int DW  = 32;
  localparam int OW  = 6;
  localparam int LAT = 2;
  localparam int UW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] req, release_lock, grant, owns, res_valid, zero, over;
  logic [IW-1:0] issue_id [NP];
  logic [DW-1:0] op_a [NP];
  logic [DW-1:0] op_b [NP];
  logic [DW-1:0] res [NP];
  logic [OW-1:0] op_code [NP];
  logic [UW-1:0] alloc_id [NP];
  logic          pool_full;

  alu_pool_pipelined #(.NUM_UNITS(NU), .NUM_PORTS(NP), .ID_WIDTH(IW), .DATA_W(DW),
                       .OP_W(OW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .issue_id(issue_id), .op_a(op_a),
    .op_b(op_b), .op_code(op_code), .release_lock(release_lock), .grant(grant),
    .alloc_id(alloc_id), .owns(owns), .res_valid(res_valid), .res(res),
    .zero(zero), .over(over), .pool_full(pool_full));

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic          z;
    logic          o;
  } vec_t;

  typedef struct {
    logic [DW-1:0] r;
    logic          z;
    logic          o;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    release_lock = '0;
    for (int p = 0; p < NP; p++) begin
      issue_id[p] = '0;
      op_a[p] = '0;
      op_b[p] = '0;
      op_code[p] = '0;
    end
  endtask

  task automatic run_op(input int i);
    exp_t e;
    int   n;
    logic got;
    tick();
    req[0] = 1'b1;
    issue_id[0] = 16'd5;
    op_code[0] = vecs[i].op;
    op_a[0] = vecs[i].a;
    op_b[0] = vecs[i].b;
    @(negedge clk);
    chk($sformatf("op%0d_grant", i), DW'(grant[0]), 1);
    chk($sformatf("op%0d_alloc", i), DW'(alloc_id[0]), 0);
    sb.push_back('{vecs[i].r, vecs[i].z, vecs[i].o});
    tick();
    req[0] = 1'b0;
    op_a[0] = $urandom;
    op_b[0] = $urandom;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      n++;
      got = res_valid[0];
    end
    chk($sformatf("op%0d_valid_seen", i), DW'(got), 1);
    if (got) begin
      e = sb.pop_front();
      chk($sformatf("op%0d_latency", i), DW'(n), LAT);
      chk($sformatf("op%0d_res", i), res[0], e.r);
      chk($sformatf("op%0d_zero", i), DW'(zero[0]), DW'(e.z));
      chk($sformatf("op%0d_over", i), DW'(over[0]), DW'(e.o));
    end
    tick();
    release_lock[0] = 1'b1;
    @(negedge clk);
    chk($sformatf("op%0d_hold", i), DW'(res_valid[0]), DW'(got));
    tick();
    release_lock[0] = 1'b0;
    @(negedge clk);
    chk($sformatf("op%0d_owns_after_rel", i), DW'(owns[0]), 0);
    chk($sformatf("op%0d_valid_after_rel", i), DW'(res_valid[0]), 0);
    chk($sformatf("op%0d_res_after_rel", i), res[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vecs[0]  = '{6'd0, 32'd7,         32'd9,         32'd16,        1'b0, 1'b0};
    vecs[1]  = '{6'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1};
    vecs[2]  = '{6'd1, 32'd5,         32'd5,         32'd0,         1'b1, 1'b0};
    vecs[3]  = '{6'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4]  = '{6'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[5]  = '{6'd3, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0};
    vecs[6]  = '{6'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
    vecs[7]  = '{6'd5, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 1'b0};
    vecs[8]  = '{6'd5, 32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
    vecs[9]  = '{6'd6, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0};
    vecs[10] = '{6'd6, 32'd3,         32'h24,        32'h30,        1'b0, 1'b0};
    vecs[11] = '{6'd7, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0};
    vecs[12] = '{6'd9, 32'd12,        32'd34,        32'd0,         1'b1, 1'b0};

    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_owns", DW'(owns), 0);
    chk("rst_valid", DW'(res_valid), 0);
    chk("rst_full", DW'(pool_full), 0);
    chk("rst_res0", res[0], 0);
    chk("rst_alloc0", DW'(alloc_id[0]), 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_op(i);

    // Five requesters, four units, ids 9,3,7,1,5.
    tick();
    issue_id[0] = 16'd9; issue_id[1] = 16'd3; issue_id[2] = 16'd7;
    issue_id[3] = 16'd1; issue_id[4] = 16'd5;
    req = '1;
    @(negedge clk);
    chk("arb_grant", DW'(grant), DW'(5'b11110));
    chk("arb_unit_p3", DW'(alloc_id[3]), 0);
    chk("arb_unit_p1", DW'(alloc_id[1]), 1);
    chk("arb_unit_p4", DW'(alloc_id[4]), 2);
    chk("arb_unit_p2", DW'(alloc_id[2]), 3);
    chk("arb_full_pre", DW'(pool_full), 0);
    tick();
    @(negedge clk);
    chk("arb_full", DW'(pool_full), 1);
    chk("arb_owns", DW'(owns), DW'(5'b11110));
    chk("arb_wait", DW'(grant), 0);
    tick();
    release_lock[1] = 1'b1;
    req = 5'b00001;
    @(negedge clk);
    chk("arb_no_same_cycle", DW'(grant[0]), 0);
    tick();
    release_lock = '0;
    @(negedge clk);
    chk("arb_regrant", DW'(grant[0]), 1);
    chk("arb_regrant_unit", DW'(alloc_id[0]), 1);
    chk("arb_full_gap", DW'(pool_full), 0);
    chk("arb_owns_after", DW'(owns), DW'(5'b11100));
    tick();
    req = '0;
    release_lock = '1;
    tick();
    release_lock = '0;
    @(negedge clk);
    chk("arb_all_free", DW'(owns), 0);

    // Equal issue_id on ports 1 and 2 compete for the last unit.
    tick();
    issue_id[0] = 16'd3; issue_id[1] = 16'd4; issue_id[2] = 16'd4;
    issue_id[3] = 16'd1; issue_id[4] = 16'd2;
    req = '1;
    @(negedge clk);
    chk("tie_grant", DW'(grant), DW'(5'b11011));
    chk("tie_unit_p1", DW'(alloc_id[1]), 3);
    tick();
    req = '0;
    release_lock = '1;
    tick();
    release_lock = '0;

    // Abort: release one cycle after grant.
    tick();
    req[0] = 1'b1; issue_id[0] = 16'd1; op_code[0] = 6'd0; op_a[0] = 32'd1; op_b[0] = 32'd1;
    @(negedge clk);
    chk("abort_grant", DW'(grant[0]), 1);
    tick();
    req[0] = 1'b0;
    release_lock[0] = 1'b1;
    @(negedge clk);
    chk("abort_owns_t1", DW'(owns[0]), 1);
    chk("abort_valid_t1", DW'(res_valid[0]), 0);
    tick();
    release_lock[0] = 1'b0;
    req[2] = 1'b1; issue_id[2] = 16'd7;
    @(negedge clk);
    chk("abort_owns_t2", DW'(owns[0]), 0);
    chk("abort_reuse_grant", DW'(grant[2]), 1);
    chk("abort_reuse_unit", DW'(alloc_id[2]), 0);
    tick();
    req[2] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | res_valid[0];
    end
    chk("abort_no_result", DW'(seen), 0);
    tick();
    release_lock[2] = 1'b1;
    tick();
    release_lock[2] = 1'b0;

    // Reset with one unit in DONE and another in EXEC.
    tick();
    req[0] = 1'b1; issue_id[0] = 16'd1; op_code[0] = 6'd0; op_a[0] = 32'd2; op_b[0] = 32'd3;
    tick();
    req[0] = 1'b0;
    tick();
    req[1] = 1'b1; issue_id[1] = 16'd2; op_code[1] = 6'd0; op_a[1] = 32'd4; op_b[1] = 32'd4;
    tick();
    req[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_done_valid", DW'(res_valid[0]), 1);
    chk("rstmid_done_res", res[0], 32'd5);
    chk("rstmid_exec_owns", DW'(owns[1]), 1);
    chk("rstmid_exec_valid", DW'(res_valid[1]), 0);
    chk("rstmid_exec_unit", DW'(alloc_id[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_owns", DW'(owns), 0);
    chk("rstmid_valid", DW'(res_valid), 0);
    chk("rstmid_res0", res[0], 0);
    chk("rstmid_alloc1", DW'(alloc_id[1]), 0);
    chk("rstmid_full", DW'(pool_full), 0);
    tick();
    rst_n = 1'b1;
    req[3] = 1'b1; issue_id[3] = 16'd9; op_code[3] = 6'd2; op_a[3] = 32'hFF; op_b[3] = 32'h0F;
    @(negedge clk);
    chk("post_rst_grant", DW'(grant[3]), 1);
    chk("post_rst_unit", DW'(alloc_id[3]), 0);
    tick();
    req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_valid", DW'(res_valid[3]), 1);
    chk("post_rst_res", res[3], 32'h0F);

    chk("sb_empty", DW'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
